// File: rtl/battleship_pkg.sv
// Shared types and default sizing for the battleship game-state core.
package battleship_pkg;

    localparam int unsigned DEF_GRID_N     = 10;
    localparam int unsigned DEF_MAX_TURNS  = 20;
    localparam int unsigned DEF_SHIP_CELLS = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        WON     = 2'd2,
        LOST    = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        MISS   = 2'd0,
        HIT    = 2'd1,
        REJECT = 2'd2
    } shot_result_t;

endpackage

// File: rtl/fired_map.sv
// Bitmap of cells already fired on, with synchronous clear, set strobe and lookup.
module fired_map
    import battleship_pkg::*;
#(
    parameter int unsigned GRID_N = DEF_GRID_N
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       set,
    input  logic [3:0]                 row,
    input  logic [3:0]                 col,
    output logic                       already_fired,
    output logic [GRID_N*GRID_N-1:0]   mask
);

    localparam int unsigned CELLS = GRID_N * GRID_N;

    logic [7:0]       idx;
    logic [CELLS-1:0] sel;
    logic [CELLS-1:0] mask_q;
    logic [CELLS-1:0] mask_d;

    // Out-of-range coordinates may alias an in-range cell; the caller rejects those anyway.
    assign idx = 8'(row) * 8'(GRID_N) + 8'(col);

    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(CELLS); i++) begin
            sel[i] = (idx == 8'(i));
        end
    end

    assign already_fired = |(mask_q & sel);

    always_comb begin
        mask_d = mask_q;
        if (clear) begin
            mask_d = '0;
        end else if (set) begin
            mask_d = mask_q | sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;

endmodule

// File: rtl/turn_tracker.sv
// Battleship game FSM: judges shots, counts hits and turns, declares win or loss.
module turn_tracker
    import battleship_pkg::*;
#(
    parameter int unsigned GRID_N     = DEF_GRID_N,
    parameter int unsigned MAX_TURNS  = DEF_MAX_TURNS,
    parameter int unsigned SHIP_CELLS = DEF_SHIP_CELLS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     fire,
    input  logic [3:0]               fire_row,
    input  logic [3:0]               fire_col,
    input  logic                     fire_hit,
    output logic [4:0]               turns_left,
    output logic [4:0]               hits,
    output logic [1:0]               game_state,
    output logic                     result_valid,
    output logic [1:0]               result,
    output logic [GRID_N*GRID_N-1:0] fired_mask
);

    game_state_t  state_q, state_d;
    shot_result_t result_q, result_d;
    logic [4:0]   turns_q, turns_d;
    logic [4:0]   hits_q, hits_d;
    logic         valid_q, valid_d;

    logic in_range;
    logic already_fired;
    logic accept;

    assign in_range = (fire_row < 4'(GRID_N)) && (fire_col < 4'(GRID_N));
    assign accept   = fire && !start && (state_q == PLAYING) && in_range && !already_fired;

    fired_map #(
        .GRID_N (GRID_N)
    ) u_fired_map (
        .clk           (clk),
        .reset         (reset),
        .clear         (start),
        .set           (accept),
        .row           (fire_row),
        .col           (fire_col),
        .already_fired (already_fired),
        .mask          (fired_mask)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        turns_d  = turns_q;
        hits_d   = hits_q;
        valid_d  = 1'b0;
        if (start) begin
            // A simultaneous fire is dropped without a result pulse.
            state_d = PLAYING;
            turns_d = 5'(MAX_TURNS);
            hits_d  = 5'd0;
        end else if (fire) begin
            valid_d = 1'b1;
            if (accept) begin
                turns_d  = turns_q - 5'd1;
                result_d = fire_hit ? HIT : MISS;
                if (fire_hit) begin
                    hits_d = hits_q + 5'd1;
                end
                // Winning on the last turn beats losing.
                if (fire_hit && (hits_q + 5'd1 == 5'(SHIP_CELLS))) begin
                    state_d = WON;
                end else if (turns_q == 5'd1) begin
                    state_d = LOST;
                end
            end else begin
                result_d = REJECT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= MISS;
            turns_q  <= 5'(MAX_TURNS);
            hits_q   <= 5'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            turns_q  <= turns_d;
            hits_q   <= hits_d;
            valid_q  <= valid_d;
        end
    end

    assign game_state   = state_q;
    assign result       = result_q;
    assign turns_left   = turns_q;
    assign hits         = hits_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_turn_tracker.sv
// Scoreboard bench for turn_tracker: default instance plus a MAX_TURNS=17 instance.
module tb_turn_tracker;

    localparam int R_MISS = 0, R_HIT = 1, R_REJ = 2;
    localparam int S_IDLE = 0, S_PLAY = 1, S_WON = 2, S_LOST = 3;

    typedef struct packed {
        logic [1:0] res;
        logic [4:0] turns;
        logic [4:0] hits;
        logic [1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        a_start = 0, a_fire = 0, a_hit = 0;
    logic [3:0]  a_row = 0, a_col = 0;
    logic [4:0]  a_turns, a_hits;
    logic [1:0]  a_state, a_result;
    logic        a_valid;
    logic [99:0] a_mask;

    logic        b_start = 0, b_fire = 0, b_hit = 0;
    logic [3:0]  b_row = 0, b_col = 0;
    logic [4:0]  b_turns, b_hits;
    logic [1:0]  b_state, b_result;
    logic        b_valid;
    logic [99:0] b_mask;

    exp_t qa[$];
    exp_t qb[$];
    int n_total = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    turn_tracker u_dut (
        .clk (clk), .reset (reset), .start (a_start), .fire (a_fire),
        .fire_row (a_row), .fire_col (a_col), .fire_hit (a_hit),
        .turns_left (a_turns), .hits (a_hits), .game_state (a_state),
        .result_valid (a_valid), .result (a_result), .fired_mask (a_mask)
    );

    turn_tracker #(
        .MAX_TURNS (17)
    ) u_dut17 (
        .clk (clk), .reset (reset), .start (b_start), .fire (b_fire),
        .fire_row (b_row), .fire_col (b_col), .fire_hit (b_hit),
        .turns_left (b_turns), .hits (b_hits), .game_state (b_state),
        .result_valid (b_valid), .result (b_result), .fired_mask (b_mask)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic shot(input int d, input int r, input int c, input bit h,
                        input int er, input int et, input int eh, input int es);
        exp_t e;
        e.res = 2'(er); e.turns = 5'(et); e.hits = 5'(eh); e.st = 2'(es);
        if (d == 0) begin
            qa.push_back(e);
            a_fire = 1; a_row = 4'(r); a_col = 4'(c); a_hit = h;
        end else begin
            qb.push_back(e);
            b_fire = 1; b_row = 4'(r); b_col = 4'(c); b_hit = h;
        end
        @(posedge clk); #1;
        a_fire = 0; b_fire = 0;
    endtask

    task automatic start_game(input int d);
        if (d == 0) a_start = 1; else b_start = 1;
        @(posedge clk); #1;
        a_start = 0; b_start = 0;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_valid) begin
            if (qa.size() == 0) begin
                check("a unexpected result_valid", 1, 0);
            end else begin
                e = qa.pop_front();
                check("a result", int'(a_result), int'(e.res));
                check("a turns_left", int'(a_turns), int'(e.turns));
                check("a hits", int'(a_hits), int'(e.hits));
                check("a game_state", int'(a_state), int'(e.st));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_valid) begin
            if (qb.size() == 0) begin
                check("b unexpected result_valid", 1, 0);
            end else begin
                e = qb.pop_front();
                check("b result", int'(b_result), int'(e.res));
                check("b turns_left", int'(b_turns), int'(e.turns));
                check("b hits", int'(b_hits), int'(e.hits));
                check("b game_state", int'(b_state), int'(e.st));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("reset state", int'(a_state), S_IDLE);
        check("reset turns", int'(a_turns), 20);
        check("reset hits", int'(a_hits), 0);
        check("reset mask", int'(a_mask == '0), 1);
        check("reset valid", int'(a_valid), 0);
        check("reset result", int'(a_result), R_MISS);

        // Fire before start.
        shot(0, 1, 1, 0, R_REJ, 20, 0, S_IDLE);
        check("idle after reject", int'(a_state), S_IDLE);

        start_game(0);
        check("start state", int'(a_state), S_PLAY);
        shot(0, 2, 3, 0, R_MISS, 19, 0, S_PLAY);
        check("mask bit 23", int'(a_mask[23]), 1);
        check("mask popcount", $countones(a_mask), 1);

        // Repeat cell back-to-back, then out-of-range coordinates.
        start_game(0);
        check("restart mask clear", int'(a_mask == '0), 1);
        shot(0, 2, 3, 1, R_HIT, 19, 1, S_PLAY);
        shot(0, 2, 3, 1, R_REJ, 19, 1, S_PLAY);
        shot(0, 10, 0, 1, R_REJ, 19, 1, S_PLAY);
        shot(0, 0, 10, 0, R_REJ, 19, 1, S_PLAY);

        // Two misses then 17 hits: win with one turn left.
        start_game(0);
        shot(0, 9, 0, 0, R_MISS, 19, 0, S_PLAY);
        shot(0, 9, 1, 0, R_MISS, 18, 0, S_PLAY);
        for (int k = 1; k <= 17; k++) begin
            shot(0, (k - 1) / 10, (k - 1) % 10, 1, R_HIT, 18 - k, k,
                 (k == 17) ? S_WON : S_PLAY);
        end
        shot(0, 5, 5, 1, R_REJ, 1, 17, S_WON);

        // 20 shots, 16 hits: lose.
        start_game(0);
        for (int i = 0; i < 20; i++) begin
            shot(0, i / 10, i % 10, (i < 16), (i < 16) ? R_HIT : R_MISS, 19 - i,
                 (i < 16) ? i + 1 : 16, (i == 19) ? S_LOST : S_PLAY);
        end
        check("lost turns zero", int'(a_turns), 0);
        shot(0, 8, 8, 1, R_REJ, 0, 16, S_LOST);

        // start and fire together mid-game.
        start_game(0);
        shot(0, 0, 0, 0, R_MISS, 19, 0, S_PLAY);
        a_start = 1; a_fire = 1; a_row = 1; a_col = 1; a_hit = 1;
        @(posedge clk); #1;
        a_start = 0; a_fire = 0;
        check("start+fire no valid", int'(a_valid), 0);
        check("start+fire turns", int'(a_turns), 20);
        check("start+fire hits", int'(a_hits), 0);
        check("start+fire mask", int'(a_mask == '0), 1);
        shot(0, 0, 0, 0, R_MISS, 19, 0, S_PLAY);

        // Asynchronous reset mid-game, checked before the next rising edge.
        shot(0, 4, 4, 1, R_HIT, 18, 1, S_PLAY);
        a_fire = 1; a_row = 6; a_col = 6; a_hit = 1;
        @(negedge clk); #2;
        reset = 1;
        #1;
        check("async reset state", int'(a_state), S_IDLE);
        check("async reset turns", int'(a_turns), 20);
        check("async reset hits", int'(a_hits), 0);
        check("async reset mask", int'(a_mask == '0), 1);
        check("async reset valid", int'(a_valid), 0);
        check("async reset result", int'(a_result), R_MISS);
        @(posedge clk); #1;
        a_fire = 0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1 check("post reset idle", int'(a_state), S_IDLE);

        // MAX_TURNS=17: last shot is also last ship cell, so WON.
        start_game(1);
        check("b start turns", int'(b_turns), 17);
        for (int i = 0; i < 17; i++) begin
            shot(1, i / 10, i % 10, 1, R_HIT, 16 - i, i + 1, (i == 16) ? S_WON : S_PLAY);
        end
        check("b final state", int'(b_state), S_WON);
        check("b final turns", int'(b_turns), 0);

        repeat (3) @(posedge clk);
        #1;
        check("a scoreboard drained", qa.size(), 0);
        check("b scoreboard drained", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/turn_tracker.md
# turn_tracker

Game-state core for the battleship VGA demo. Accepts shot requests from the input front end, rejects illegal or repeated shots, and counts hits and remaining turns. Declares win or loss. Drives `turns_left` to the seven-segment controller directly downstream. Drives `fired_mask` to the VGA renderer for shot overlay.

## Interface
Parameters:
- `GRID_N`, default 10: board is GRID_N x GRID_N cells; must be ≤ 15.
- `MAX_TURNS`, default 20: turns granted per game; must be ≤ 31.
- `SHIP_CELLS`, default 17: total ship cells; reaching this hit count wins; must be ≤ 31.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a new game.
- `fire`  in  1  one-cycle pulse requesting a shot at `fire_row`/`fire_col`.
- `fire_row`  in  4  target row; sampled with `fire`.
- `fire_col`  in  4  target column; sampled with `fire`.
- `fire_hit`  in  1  ship-map lookup for the target; valid in the same cycle as `fire`.
- `turns_left`  out  5  registered count of remaining turns.
- `hits`  out  5  registered count of accepted hits.
- `game_state`  out  2  registered state: IDLE=0, PLAYING=1, WON=2, LOST=3.
- `result_valid`  out  1  one-cycle pulse, asserted the cycle after `fire`.
- `result`  out  2  valid with `result_valid`: MISS=0, HIT=1, REJECT=2; holds its last value otherwise.
- `fired_mask`  out  GRID_N*GRID_N  registered bitmap of cells already fired on; bit index is row*GRID_N+col.

## Operation
Reset values:
- `game_state` = IDLE, `turns_left` = MAX_TURNS, `hits` = 0.
- `fired_mask` = 0, `result_valid` = 0, `result` = MISS.

FSM transitions:
- IDLE → PLAYING on `start`.
- PLAYING → WON when an accepted hit brings `hits` to SHIP_CELLS.
- PLAYING → LOST when an accepted shot brings `turns_left` to 0 and the game is not won.
- WON/LOST → PLAYING on `start`.

On every `start`, from any state including PLAYING:
- `turns_left` ← MAX_TURNS, `hits` ← 0, `fired_mask` ← 0.
- `start` takes priority over `fire` in the same cycle; that `fire` is dropped and produces no `result_valid`.

Every `fire` produces exactly one `result_valid` pulse, unless it is dropped by a simultaneous `start`.

A shot is rejected (`result` = REJECT, no state change) if any of these hold:
- `game_state` ≠ PLAYING;
- `fire_row` ≥ GRID_N or `fire_col` ≥ GRID_N;
- the target bit of `fired_mask` is already set.

An accepted shot does all of the following:
- sets its `fired_mask` bit;
- decrements `turns_left` by 1;
- if `fire_hit` = 1, increments `hits` by 1 and returns HIT; otherwise returns MISS.

Boundary rules:
- If the final turn is also the final ship cell, WON takes priority over LOST; `turns_left` still reads 0.
- `turns_left` never underflows and `hits` never exceeds SHIP_CELLS, because shots are rejected outside PLAYING.

## Timing
- Latency: `fire` in cycle N gives `result_valid`/`result` in cycle N+1. In that same cycle N+1, `turns_left`, `hits`, `fired_mask` and `game_state` show their updated values.
- `fire` asserted in back-to-back cycles is legal. Each shot is judged against the mask as updated by the previous shot, so a repeated cell in cycle N+1 returns REJECT.
- `start` in cycle N: the cleared counters and PLAYING are visible in cycle N+1.
- Reset asserted mid-game forces all outputs to their reset values immediately, without waiting for a clock edge. No pending result is emitted after reset is released.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `battleship_pkg` holds:
  - `game_state_t` enum (IDLE, PLAYING, WON, LOST);
  - `shot_result_t` codes (MISS, HIT, REJECT);
  - default values of GRID_N, MAX_TURNS and SHIP_CELLS.
- One sub-module, `fired_map`. It holds the GRID_N*GRID_N bitmap and provides:
  - a synchronous clear;
  - a set-on-accept strobe;
  - a combinational `already_fired` lookup for the incoming coordinate.
- The FSM, the counters and the result register stay in `turn_tracker`.

## Test plan
- Reset, then `start`, then `fire` at (2,3) with `fire_hit`=0 → next cycle: `result`=MISS, `turns_left`=19, `hits`=0, mask bit 23 set.
- Fire at (2,3) twice in consecutive cycles, first with `fire_hit`=1 → results HIT then REJECT; `turns_left`=19, `hits`=1.
- `fire` before `start` → REJECT, state stays IDLE. Fire at (10,0) during PLAYING → REJECT, counters unchanged.
- 17 distinct hits within 20 shots → WON on the cycle after the 17th hit. A further `fire` → REJECT.
- 20 distinct shots with 16 hits → LOST, `turns_left`=0. Run again with MAX_TURNS=17 and 17 hits → WON, not LOST.
- `start` and `fire` in the same cycle mid-game → counters reset, no `result_valid`. Reset asserted mid-game → all outputs at reset values before the next clock edge.
